alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Sequential front-end for the processor's 32-bit combinational ALU: accepts one operation (5-bit opcode plus two operands) over a valid/ready handshake, drives the ALU's opcode/A/B inputs, waits a configurable settle time, captures the ALU result, derives the status flags (zero, negative, carry, overflow), and presents them over a second valid/ready handshake. Sits between the decode/register-read stage and write-back/flag register. Flags are computed here from registered operands and the ALU result; the ALU's own flag outputs are not used.

## Interface
- DATA_W, 32, operand/result width
- OPC_W, 5, opcode width
- SETTLE, 1, cycles the ALU inputs are held stable before the result is sampled (≥1)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept; high only in IDLE
- in_op  in  OPC_W  ALU opcode
- in_a, in_b  in  DATA_W  signed operands
- alu_opcode  out  OPC_W  to ALU opcode
- alu_a, alu_b  out  DATA_W  to ALU A/B
- alu_out  in  DATA_W  from ALU result
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  DATA_W  captured result
- res_zero, res_neg, res_carry, res_ovf  out  1  status flags
- res_err  out  1  opcode was illegal

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE: in_ready=1. On in_valid: register in_op/in_a/in_b onto alu_opcode/alu_a/alu_b, load settle counter with SETTLE-1, go EXEC.
- EXEC: ALU inputs held constant. Counter decrements each cycle; at 0, sample alu_out into res_data, compute flags, go DONE.
- DONE: res_valid=1, res_* stable. On res_ready: go IDLE (new request accepted no earlier than the next cycle).
- Legal opcodes: 00000 add, 00001 addinc, 00011 inca, 00100 subdec, 00101 sub, 00110 deca, 01000 lsl, 01001 asr, 10000–11111 logic/pass/zeros/ones.
- Illegal opcodes (00010, 00111, 01010–01111): no settle; straight IDLE→DONE next cycle with res_data=0, res_err=1, all other flags 0; alu_opcode still registered.
- res_zero = (res_data==0); res_neg = res_data[DATA_W-1] (legal ops only).
- Carry from a local (DATA_W+1)-bit computation on registered operands: add=a+b, addinc=a+b+1, inca=a+1 → carry-out bit; sub=a−b, subdec=a−b−1, deca=a−1 → carry=1 on unsigned borrow; lsl → a[MSB]; asr → a[0]; logic group → 0.
- Overflow (see Configuration): add-class: sign(a)==sign(b_eff) and sign(res)≠sign(a); sub-class: sign(a)≠sign(b_eff) and sign(res)≠sign(a); b_eff=1 for inca/deca; all others 0.

## Timing
- Reset (async assert, sync-free deassert at next clk): state IDLE, in_ready=1, res_valid=0, res_err=0, all flags 0, res_data=0, alu_opcode=0, alu_a=alu_b=0.
- Accept at edge N → EXEC N..N+SETTLE−1 → res_valid high from edge N+SETTLE+1? No: res_valid high after edge N+SETTLE+… defined as: result sampled at edge N+SETTLE, res_valid high in cycle after it. SETTLE=1: accept edge 0, sample edge 1, res_valid high cycles 1→ until res_ready.
- Illegal opcode: res_valid high after edge N+1 regardless of SETTLE.
- Throughput: one op per SETTLE+2 cycles with res_ready held high.
- in_valid during EXEC/DONE ignored (in_ready=0); upstream must hold its request.
- res_ready while res_valid=0: no effect.
- rst_n low mid-EXEC or DONE: operation discarded, all outputs to reset values immediately.

## Configuration
- ALU_OVF_DETECT_EN defined: res_ovf computed as above.
- Not defined: res_ovf tied 0, overflow logic absent; all other behaviour identical.

## Structure
- Shared package alu_pkg: opcode constants (OP_ADD … OP_ONES), opcode-class function/enum (ADD, SUB, SHIFT, LOGIC, ILLEGAL), FSM state typedef.
- One natural sub-module: alu_flag_gen (combinational: class, registered a/b, alu_out → carry, ovf, zero, neg).

## Test plan
- Reset with rst_n=0 mid-EXEC → in_ready=1, res_valid=0, all flags 0 same cycle.
- add a=0x7FFFFFFF, b=1 → res_data=0x80000000, neg=1, ovf=1, carry=0, zero=0.
- sub a=5, b=5 → res_data=0, zero=1, carry=0; deca a=0 → 0xFFFFFFFF, carry=1, ovf=0.
- lsl a=0x80000001 → res_data=0x00000002, carry=1; asr a=0x80000001 → 0xC0000000, carry=1.
- opcode 00010 → res_valid one cycle after accept, res_err=1, res_data=0; then hold res_ready=0 for 5 cycles → outputs stable, in_ready=0, second in_valid ignored.
- SETTLE=3, back-to-back ops with res_ready=1 → one result every 5 cycles; rebuild without ALU_OVF_DETECT_EN → res_ovf=0 for case 2.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the ALU issue controller: opcode
//                constants, opcode classification and the FSM state type.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    // Arithmetic opcodes
    localparam logic [4:0] OP_ADD      = 5'b00000;
    localparam logic [4:0] OP_ADDINC   = 5'b00001;
    localparam logic [4:0] OP_INCA     = 5'b00011;
    localparam logic [4:0] OP_SUBDEC   = 5'b00100;
    localparam logic [4:0] OP_SUB      = 5'b00101;
    localparam logic [4:0] OP_DECA     = 5'b00110;
    // Shifts by one position
    localparam logic [4:0] OP_LSL      = 5'b01000;
    localparam logic [4:0] OP_ASR      = 5'b01001;
    // Logic / pass / zeros / ones group occupies 10000..11111
    localparam logic [4:0] OP_LOGIC_LO = 5'b10000;
    localparam logic [4:0] OP_ONES     = 5'b11111;

    typedef enum logic [2:0] {
        CLS_ADD     = 3'd0,
        CLS_SUB     = 3'd1,
        CLS_SHIFT   = 3'd2,
        CLS_LOGIC   = 3'd3,
        CLS_ILLEGAL = 3'd4
    } op_class_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic op_class_e op_class(input logic [4:0] op);
        op_class_e cls;
        cls = CLS_ILLEGAL;
        if (op >= OP_LOGIC_LO) begin
            cls = CLS_LOGIC;
        end else begin
            case (op)
                OP_ADD, OP_ADDINC, OP_INCA: cls = CLS_ADD;
                OP_SUBDEC, OP_SUB, OP_DECA: cls = CLS_SUB;
                OP_LSL, OP_ASR:             cls = CLS_SHIFT;
                default:                    cls = CLS_ILLEGAL;
            endcase
        end
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_flag_gen.sv
`default_nettype none
// ============================================================================
//  Module      : alu_flag_gen
//  Description : Combinational status-flag generator. Carry is recomputed
//                locally from the registered operands; zero/negative and
//                overflow are derived from the ALU result.
//  Revision    : 1.0  initial release
//  Config      : ALU_OVF_DETECT_EN - when undefined, ovf is tied 0 and the
//                overflow logic is not built.
//  Ports       : op_cls  - class of the registered opcode
//                opcode  - registered opcode (selects carry-in / b override)
//                a, b    - registered operands
//                result  - ALU result
//                carry, ovf, zero, neg - derived flags
// ============================================================================
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  op_class_e         op_cls,
    input  logic [4:0]        opcode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              ovf,
    output logic              zero,
    output logic              neg
);

    logic [DATA_W-1:0] w_b_eff;
    logic              w_cin;
    logic [DATA_W:0]   w_cin_ext;
    logic              w_add_carry;
    logic              w_sub_borrow;

    // inca/deca use a constant 1 as second operand; addinc/subdec add an
    // extra +1 / -1 through w_cin.
    always_comb begin
        w_b_eff = b;
        w_cin   = 1'b0;
        case (opcode)
            OP_ADDINC: w_cin   = 1'b1;
            OP_INCA:   w_b_eff = DATA_W'(1);
            OP_SUBDEC: w_cin   = 1'b1;
            OP_DECA:   w_b_eff = DATA_W'(1);
            default:   ;
        endcase
    end

    assign w_cin_ext = {{DATA_W{1'b0}}, w_cin};

    // Only the top bit of the (DATA_W+1)-bit sum/difference is wanted, so it
    // is extracted by shifting rather than keeping an unused full-width sum.
    assign w_add_carry  = |(({1'b0, a} + {1'b0, w_b_eff} + w_cin_ext) >> DATA_W);
    assign w_sub_borrow = |(({1'b0, a} - {1'b0, w_b_eff} - w_cin_ext) >> DATA_W);

    always_comb begin
        carry = 1'b0;
        case (op_cls)
            CLS_ADD:   carry = w_add_carry;
            CLS_SUB:   carry = w_sub_borrow;
            CLS_SHIFT: carry = (opcode == OP_LSL) ? a[DATA_W-1] : a[0];
            default:   carry = 1'b0;
        endcase
    end

`ifdef ALU_OVF_DETECT_EN
    logic w_sa;
    logic w_sb;
    logic w_sr;

    assign w_sa = a[DATA_W-1];
    assign w_sb = w_b_eff[DATA_W-1];
    assign w_sr = result[DATA_W-1];

    always_comb begin
        ovf = 1'b0;
        case (op_cls)
            CLS_ADD: ovf = (w_sa == w_sb) && (w_sr != w_sa);
            CLS_SUB: ovf = (w_sa != w_sb) && (w_sr != w_sa);
            default: ovf = 1'b0;
        endcase
    end
`else
    assign ovf = 1'b0;
`endif

    assign zero = (result == '0);
    assign neg  = result[DATA_W-1];

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_ctrl
//  Description : Sequential front-end for a combinational 32-bit ALU. Accepts
//                an operation over valid/ready, holds the ALU inputs for
//                SETTLE cycles, captures the result with derived flags and
//                presents it over a second valid/ready handshake.
//  Revision    : 1.0  initial release
//  Config      : ALU_OVF_DETECT_EN - enables overflow flag (else res_ovf=0)
//  Ports       : clk, rst_n                    - clock / async active-low reset
//                in_valid/in_ready/in_op/in_a/in_b - request side
//                alu_opcode/alu_a/alu_b/alu_out    - ALU connection
//                res_valid/res_ready/res_data      - result side
//                res_zero/res_neg/res_carry/res_ovf/res_err - status
// ============================================================================
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OPC_W  = 5,
    parameter int SETTLE = 1     // must be >= 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPC_W-1:0]  in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [OPC_W-1:0]  alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_zero,
    output logic              res_neg,
    output logic              res_carry,
    output logic              res_ovf,
    output logic              res_err
);

    localparam int                c_cnt_w       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [c_cnt_w-1:0] c_settle_load = c_cnt_w'(SETTLE - 1);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [OPC_W-1:0]    r_opcode;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_res_data;
    logic                r_zero;
    logic                r_neg;
    logic                r_carry;
    logic                r_ovf;
    logic                r_err;

    logic                w_in_ready;
    logic                w_res_valid;
    logic                w_accept;
    logic                w_sample;
    op_class_e           w_cls;
    logic                w_in_illegal;
    logic                w_fg_carry;
    logic                w_fg_ovf;
    logic                w_fg_zero;
    logic                w_fg_neg;

    assign w_cls        = op_class(5'(r_opcode));
    assign w_in_illegal = (op_class(5'(in_op)) == CLS_ILLEGAL);
    assign w_accept     = (r_state == ST_IDLE) && in_valid;
    assign w_sample     = (r_state == ST_EXEC) && (r_cnt == '0);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)     w_state_nxt = ST_EXEC;
            ST_EXEC: if (r_cnt == '0)  w_state_nxt = ST_DONE;
            ST_DONE: if (res_ready)    w_state_nxt = ST_IDLE;
            default:                   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready  = 1'b0;
        w_res_valid = 1'b0;
        case (r_state)
            ST_IDLE: w_in_ready  = 1'b1;
            ST_DONE: w_res_valid = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------- datapath
    // Illegal opcodes pass through EXEC with a zero count, so their result
    // appears one cycle after accept irrespective of SETTLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_opcode   <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_res_data <= '0;
            r_zero     <= 1'b0;
            r_neg      <= 1'b0;
            r_carry    <= 1'b0;
            r_ovf      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_opcode <= in_op;
                r_a      <= in_a;
                r_b      <= in_b;
                r_cnt    <= w_in_illegal ? '0 : c_settle_load;
            end else if ((r_state == ST_EXEC) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - c_cnt_w'(1);
            end

            if (w_sample) begin
                if (w_cls == CLS_ILLEGAL) begin
                    r_res_data <= '0;
                    r_zero     <= 1'b0;
                    r_neg      <= 1'b0;
                    r_carry    <= 1'b0;
                    r_ovf      <= 1'b0;
                    r_err      <= 1'b1;
                end else begin
                    r_res_data <= alu_out;
                    r_zero     <= w_fg_zero;
                    r_neg      <= w_fg_neg;
                    r_carry    <= w_fg_carry;
                    r_ovf      <= w_fg_ovf;
                    r_err      <= 1'b0;
                end
            end
        end
    end

    alu_flag_gen #(
        .DATA_W (DATA_W)
    ) u_flag_gen (
        .op_cls (w_cls),
        .opcode (5'(r_opcode)),
        .a      (r_a),
        .b      (r_b),
        .result (alu_out),
        .carry  (w_fg_carry),
        .ovf    (w_fg_ovf),
        .zero   (w_fg_zero),
        .neg    (w_fg_neg)
    );

    assign in_ready   = w_in_ready;
    assign res_valid  = w_res_valid;
    assign alu_opcode = r_opcode;
    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign res_data   = r_res_data;
    assign res_zero   = r_zero;
    assign res_neg    = r_neg;
    assign res_carry  = r_carry;
    assign res_ovf    = r_ovf;
    assign res_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_issue_ctrl
//  Description : Self-checking bench for alu_issue_ctrl with a behavioural
//                ALU and an arithmetic reference model for result and flags.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_issue_ctrl;

    localparam int DW        = 32;
    localparam int OW        = 5;
    localparam int TB_SETTLE = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [OW-1:0] in_op = '0;
    logic [DW-1:0] in_a = '0;
    logic [DW-1:0] in_b = '0;
    logic [OW-1:0] alu_opcode;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [DW-1:0] alu_out;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [DW-1:0] res_data;
    logic          res_zero, res_neg, res_carry, res_ovf, res_err;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(
        .DATA_W (DW),
        .OPC_W  (OW),
        .SETTLE (TB_SETTLE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_out    (alu_out),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_zero   (res_zero),
        .res_neg    (res_neg),
        .res_carry  (res_carry),
        .res_ovf    (res_ovf),
        .res_err    (res_err)
    );

    // Behavioural ALU; illegal opcodes produce junk the controller must drop.
    function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            5'd0:  return a + b;
            5'd1:  return a + b + 32'd1;
            5'd3:  return a + 32'd1;
            5'd4:  return a - b - 32'd1;
            5'd5:  return a - b;
            5'd6:  return a - 32'd1;
            5'd8:  return a << 1;
            5'd9:  return {a[31], a[31:1]};
            5'd16: return a & b;
            5'd17: return a | b;
            5'd18: return a ^ b;
            5'd30: return 32'h0;
            5'd31: return 32'hFFFF_FFFF;
            default: return op[4] ? a : 32'hDEAD_BEEF;
        endcase
    endfunction

    assign alu_out = alu_fn(alu_opcode, alu_a, alu_b);

    function automatic bit is_legal(input logic [4:0] op);
        return op[4] || (op inside {5'd0, 5'd1, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9});
    endfunction

    function automatic logic exp_carry(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint unsigned ua = {32'h0, a};
        longint unsigned ub = {32'h0, b};
        case (op)
            5'd0: return ((ua + ub) >> 32) != 0;
            5'd1: return ((ua + ub + 1) >> 32) != 0;
            5'd3: return ((ua + 1) >> 32) != 0;
            5'd5: return ua < ub;
            5'd4: return ua < (ub + 1);
            5'd6: return ua == 0;
            5'd8: return a[31];
            5'd9: return a[0];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic exp_ovf(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef ALU_OVF_DETECT_EN
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint s;
        case (op)
            5'd0: s = sa + sb;
            5'd1: s = sa + sb + 1;
            5'd3: s = sa + 1;
            5'd5: s = sa - sb;
            5'd4: s = sa - sb - 1;
            5'd6: s = sa - 1;
            default: return 1'b0;
        endcase
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
`else
        return (op == 5'd31) && (a == b) && 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction with cycle-exact latency checks.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        bit          legal;
        int          lat;
        legal = is_legal(op);
        r     = legal ? alu_fn(op, a, b) : 32'h0;
        lat   = legal ? TB_SETTLE : 1;
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        tick();
        in_valid = 1'b0; in_op = 5'($urandom); in_a = $urandom; in_b = $urandom;
        chk("alu_opcode", alu_opcode, op);
        chk("alu_a", alu_a, a);
        chk("alu_b", alu_b, b);
        for (int k = 0; k < lat; k++) begin
            chk("res_valid_early", res_valid, 0);
            chk("in_ready_busy", in_ready, 0);
            res_ready = 1'($urandom_range(0, 1));
            tick();
        end
        res_ready = 1'b0;
        chk("res_valid", res_valid, 1);
        chk("res_data", res_data, r);
        chk("res_zero", res_zero, legal && (r == 32'h0));
        chk("res_neg", res_neg, legal && r[31]);
        chk("res_carry", res_carry, legal && exp_carry(op, a, b));
        chk("res_ovf", res_ovf, legal && exp_ovf(op, a, b));
        chk("res_err", res_err, !legal);
        chk("alu_a_held", alu_a, a);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("res_valid_drop", res_valid, 0);
        chk("in_ready_back", in_ready, 1);
    endtask

    initial begin
        logic [31:0] specials [5];
        logic [4:0]  legal_ops [13];
        logic [4:0]  rop;
        logic [31:0] ra, rb;
        int          prev, n_res;
        specials  = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        legal_ops = '{5'd0, 5'd1, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9,
                      5'd16, 5'd17, 5'd18, 5'd30, 5'd31};

        // Reset state
        tick(); tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_flags", {res_zero, res_neg, res_carry, res_ovf, res_err}, 0);
        chk("rst_alu", {alu_opcode, alu_a, alu_b}, 0);
        @(negedge clk); rst_n = 1'b1;
        tick();

        // Directed boundary cases
        run_op(5'd0, 32'h7FFF_FFFF, 32'h1);
        run_op(5'd5, 32'd5, 32'd5);
        run_op(5'd6, 32'h0, $urandom);
        run_op(5'd8, 32'h8000_0001, 32'h0);
        run_op(5'd9, 32'h8000_0001, 32'h0);

        // Asynchronous reset in the middle of EXEC
        in_valid = 1'b1; in_op = 5'd0; in_a = 32'h1234_5678; in_b = 32'h1;
        tick();
        in_valid = 1'b0;
        chk("exec_busy", in_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 1);
        chk("arst_res_valid", res_valid, 0);
        chk("arst_res_data", res_data, 0);
        chk("arst_flags", {res_zero, res_neg, res_carry, res_ovf, res_err}, 0);
        chk("arst_alu", {alu_opcode, alu_a, alu_b}, 0);
        @(negedge clk); rst_n = 1'b1;
        tick();
        chk("arst_after", {in_ready, res_valid}, 2'b10);

        // Illegal opcode with a stalled consumer and an ignored request
        in_valid = 1'b1; in_op = 5'b00010; in_a = $urandom; in_b = $urandom;
        tick();
        in_valid = 1'b0;
        chk("ill_opcode_reg", alu_opcode, 5'b00010);
        chk("ill_valid_early", res_valid, 0);
        tick();
        chk("ill_res_valid", res_valid, 1);
        chk("ill_res_err", res_err, 1);
        chk("ill_res_data", res_data, 0);
        chk("ill_flags", {res_zero, res_neg, res_carry, res_ovf}, 0);
        in_valid = 1'b1; in_op = 5'd0; in_a = 32'h1; in_b = 32'h1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("hold_valid", res_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_data", {res_err, res_data}, {1'b1, 32'h0});
            chk("hold_opcode", alu_opcode, 5'b00010);
        end
        in_valid = 1'b0; res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("ill_release", {in_ready, res_valid}, 2'b10);

        // Back-to-back throughput with both sides always willing
        in_valid = 1'b1; res_ready = 1'b1;
        in_op = 5'd0; in_a = 32'd100; in_b = 32'd23;
        prev = -1; n_res = 0;
        for (int cyc = 0; cyc < 21; cyc++) begin
            tick();
            if (res_valid) begin
                if (prev >= 0) chk("b2b_period", 64'(cyc - prev), TB_SETTLE + 2);
                chk("b2b_data", res_data, 32'd123);
                prev = cyc;
                n_res++;
            end
        end
        chk("b2b_count", 64'(n_res), 4);
        in_valid = 1'b0;
        repeat (6) tick();
        res_ready = 1'b0;

        // Randomized operations
        for (int n = 0; n < 60; n++) begin
            rop = ($urandom_range(0, 9) < 7) ? legal_ops[$urandom_range(0, 12)] : 5'($urandom);
            ra  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
            run_op(rop, ra, rb);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
